// File: rtl/time_of_day_12h_if.sv
`default_nettype none
// ============================================================================
// Module  : time_of_day_12h_if
// Brief   : Control inputs and BCD display outputs of the 12-hour clock core.
//           master = user/display side, slave = timekeeping core.
// Revision: 1.0 - initial release
// ============================================================================
interface time_of_day_12h_if;
  logic       setMode;
  logic       incHour;
  logic       incMinute;
  logic [3:0] secondsOnes;
  logic [3:0] secondsTens;
  logic [3:0] minutesOnes;
  logic [3:0] minutesTens;
  logic [3:0] hoursOnes;
  logic [3:0] hoursTens;
  logic [3:0] amPmCode;
  logic       hourChime;

  modport master (
    output setMode, incHour, incMinute,
    input  secondsOnes, secondsTens, minutesOnes, minutesTens,
    input  hoursOnes, hoursTens, amPmCode, hourChime
  );

  modport slave (
    input  setMode, incHour, incMinute,
    output secondsOnes, secondsTens, minutesOnes, minutesTens,
    output hoursOnes, hoursTens, amPmCode, hourChime
  );
endinterface
`default_nettype wire

// File: rtl/time_of_day_12h.sv
`default_nettype none
// ============================================================================
// Module  : time_of_day_12h
// Brief   : 1 s prescaler plus 12-hour BCD time of day with AM/PM flag,
//           hour chime and push-button set mode.
// Revision: 1.0 - initial release
// ============================================================================
module time_of_day_12h #(
  parameter int TICKS_PER_SECOND = 50_000_000
) (
  input  logic               clk,
  input  logic               resetN,
  time_of_day_12h_if.slave   tod
);

  localparam int              PW   = $clog2(TICKS_PER_SECOND);
  localparam logic [PW-1:0]   LAST = PW'(TICKS_PER_SECOND - 1);
  localparam logic [PW-1:0]   ONE  = PW'(1);

  // Registered state
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_o_q, sec_t_q, min_o_q, min_t_q, hr_o_q, hr_t_q;
  logic [3:0]    sec_o_d, sec_t_d, min_o_d, min_t_d, hr_o_d, hr_t_d;
  logic          pm_q, pm_d;
  logic          chime_q, chime_d;
  logic          inc_hour_q, inc_min_q;

  // Decoded events
  logic sec_tick, hr_edge, min_edge, sec_wrap, hour_carry;
  logic min_step, hour_step;

  // Next-state: prescaler, ripple carries and button-driven advances
  always_comb begin
    sec_tick   = !tod.setMode && (presc_q == LAST);
    hr_edge    = tod.incHour && !inc_hour_q;
    min_edge   = tod.incMinute && !inc_min_q;
    sec_wrap   = sec_tick && (sec_t_q == 4'd5) && (sec_o_q == 4'd9);
    hour_carry = sec_wrap && (min_t_q == 4'd5) && (min_o_q == 4'd9);
    // Set mode never carries minutes into hours; only run mode ripples.
    min_step   = tod.setMode ? min_edge : sec_wrap;
    hour_step  = tod.setMode ? hr_edge  : hour_carry;

    presc_d = (tod.setMode || sec_tick) ? '0 : presc_q + ONE;
    sec_o_d = sec_o_q;
    sec_t_d = sec_t_q;
    min_o_d = min_o_q;
    min_t_d = min_t_q;
    hr_o_d  = hr_o_q;
    hr_t_d  = hr_t_q;
    pm_d    = pm_q;
    chime_d = hour_carry;

    if (tod.setMode) begin
      sec_o_d = 4'd0;
      sec_t_d = 4'd0;
    end else if (sec_tick) begin
      if (sec_o_q == 4'd9) begin
        sec_o_d = 4'd0;
        sec_t_d = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
      end else begin
        sec_o_d = sec_o_q + 4'd1;
      end
    end

    if (min_step) begin
      if (min_o_q == 4'd9) begin
        min_o_d = 4'd0;
        min_t_d = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
      end else begin
        min_o_d = min_o_q + 4'd1;
      end
    end

    // Hour sequence 12 -> 1 -> ... -> 11 -> 12; AM/PM flips entering 12.
    if (hour_step) begin
      if (hr_t_q == 4'd1 && hr_o_q == 4'd2) begin
        hr_t_d = 4'd0;
        hr_o_d = 4'd1;
      end else if (hr_t_q == 4'd1 && hr_o_q == 4'd1) begin
        hr_o_d = 4'd2;
        pm_d   = !pm_q;
      end else if (hr_o_q == 4'd9) begin
        hr_t_d = 4'd1;
        hr_o_d = 4'd0;
      end else begin
        hr_o_d = hr_o_q + 4'd1;
      end
    end
  end

  // State registers; async reset to 12:00:00 AM, buttons treated as held
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc_q    <= '0;
      sec_o_q    <= 4'd0;
      sec_t_q    <= 4'd0;
      min_o_q    <= 4'd0;
      min_t_q    <= 4'd0;
      hr_o_q     <= 4'd2;
      hr_t_q     <= 4'd1;
      pm_q       <= 1'b0;
      chime_q    <= 1'b0;
      inc_hour_q <= 1'b1;
      inc_min_q  <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      sec_o_q    <= sec_o_d;
      sec_t_q    <= sec_t_d;
      min_o_q    <= min_o_d;
      min_t_q    <= min_t_d;
      hr_o_q     <= hr_o_d;
      hr_t_q     <= hr_t_d;
      pm_q       <= pm_d;
      chime_q    <= chime_d;
      inc_hour_q <= tod.incHour;
      inc_min_q  <= tod.incMinute;
    end
  end

  assign tod.secondsOnes = sec_o_q;
  assign tod.secondsTens = sec_t_q;
  assign tod.minutesOnes = min_o_q;
  assign tod.minutesTens = min_t_q;
  assign tod.hoursOnes   = hr_o_q;
  assign tod.hoursTens   = hr_t_q;
  assign tod.amPmCode    = {3'b000, pm_q};
  assign tod.hourChime   = chime_q;

endmodule
`default_nettype wire
